pool_if_neuron: RTL and testbench

- Downstream consumer of the 2x2 mean-pooling stage.
- Treats each pooled value as input current to one integrate-and-fire neuron per pooled pixel, and emits a 1-bit spike map.
- Membrane potentials persist across frames, one frame per time step, until cleared.
- The output stream keeps the vsync/hsync/range/valid framing of the pooling stage, so the next 1-bit layer can consume it unchanged.

---
 rtl/pool_if_neuron.sv | 163 ++++++++++++++++
 tb/tb_pool_if_neuron.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pool_if_neuron.sv
`timescale 1ns/1ps
// Integrate-and-fire layer: one neuron per pooled pixel that persists across frames and emits a 1-bit spike map.
// Latency: 2 cycles for data and framing alike. No backpressure: every accepted beat yields one output beat.
module pool_if_neuron #(
  parameter int IW      = 3,
  parameter int VW      = 8,
  parameter int THRESH  = 4,
  parameter int MAX_PIX = 196,
  parameter int AW      = 8
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          i_vsync,
  input  logic          i_hsync,
  input  logic          i_range,
  input  logic          i_valid,
  input  logic [IW-1:0] i_tdata,
  input  logic          i_clr,
  output logic          o_vsync,
  output logic          o_hsync,
  output logic          o_range,
  output logic          o_valid,
  output logic          o_spike,
  output logic          o_ovf
);

  localparam int            SW      = VW + 1;
  localparam logic [AW:0]   PIX_LIM = (AW+1)'(MAX_PIX);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [SW-1:0] THR     = SW'(THRESH);
  localparam logic [SW-1:0] VMAX    = SW'((1 << VW) - 1);

  // ---------------- pixel counter and frame control ----------------
  // The counter is one bit wider than the RAM address so it can park at MAX_PIX
  // without wrapping when MAX_PIX == 2^AW.
  logic [AW:0] pix_cnt_q, pix_cnt_d;
  logic        first_pass_q, first_pass_d;
  logic        rst_pend_q, rst_pend_d;
  logic        ovf_q, ovf_d;
  logic        in_rng, accept, drop;

  assign in_rng = (pix_cnt_q < PIX_LIM);
  assign accept = i_valid & ~i_vsync & in_rng;
  assign drop   = i_valid & ~i_vsync & ~in_rng;

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    first_pass_d = first_pass_q;
    rst_pend_d   = rst_pend_q;
    ovf_d        = ovf_q | drop;
    if (i_vsync) begin
      pix_cnt_d    = '0;
      // A reset forces the first frame after it to start from empty membranes.
      first_pass_d = i_clr | rst_pend_q;
      rst_pend_d   = 1'b0;
    end else if (accept) begin
      pix_cnt_d    = pix_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      pix_cnt_q    <= '0;
      first_pass_q <= 1'b1;
      rst_pend_q   <= 1'b1;
      ovf_q        <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      first_pass_q <= first_pass_d;
      rst_pend_q   <= rst_pend_d;
      ovf_q        <= ovf_d;
    end
  end

  // ---------------- framing delay line ----------------
  logic [2:0] frm_d1_q, frm_q;

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      frm_d1_q <= '0;
      frm_q    <= '0;
    end else begin
      frm_d1_q <= {i_vsync, i_hsync, i_range};
      frm_q    <= frm_d1_q;
    end
  end

  // ---------------- stage 1: membrane read ----------------
  logic          s1_vld_q;
  logic [AW-1:0] s1_addr_q;
  logic [IW-1:0] s1_dat_q;
  logic          s1_fp_q;
  logic [VW-1:0] ram_q;
  logic          byp_q;
  logic [VW-1:0] wb_q;
  logic          we;
  logic [VW-1:0] v_new;

  assign we = s1_vld_q & i_rstn;

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_dat_q  <= '0;
      s1_fp_q   <= 1'b1;
      byp_q     <= 1'b0;
      wb_q      <= '0;
    end else begin
      s1_vld_q  <= accept;
      s1_addr_q <= pix_cnt_q[AW-1:0];
      s1_dat_q  <= i_tdata;
      s1_fp_q   <= first_pass_q;
      // RAM read returns pre-write data on a same-address collision.
      byp_q     <= accept & we & (s1_addr_q == pix_cnt_q[AW-1:0]);
      wb_q      <= v_new;
    end
  end

  logic [VW-1:0] mem [MAX_PIX];

  always_ff @(posedge i_sclk) begin
    if (we) begin
      mem[s1_addr_q] <= v_new;
    end
    if (accept) begin
      ram_q <= mem[pix_cnt_q[AW-1:0]];
    end
  end

  // ---------------- stage 2: integrate, fire, write back ----------------
  logic [VW-1:0] rd_v;
  logic [SW-1:0] sum, rem;
  logic          spike;

  always_comb begin
    rd_v  = s1_fp_q ? '0 : (byp_q ? wb_q : ram_q);
    sum   = {1'b0, rd_v} + SW'(s1_dat_q);
    spike = (sum >= THR);
    rem   = spike ? (sum - THR) : sum;
    v_new = (rem > VMAX) ? VMAX[VW-1:0] : rem[VW-1:0];
  end

  logic o_valid_q, o_spike_q;

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      o_valid_q <= 1'b0;
      o_spike_q <= 1'b0;
    end else begin
      o_valid_q <= s1_vld_q;
      o_spike_q <= s1_vld_q & spike;
    end
  end

  assign o_vsync = frm_q[2];
  assign o_hsync = frm_q[1];
  assign o_range = frm_q[0];
  assign o_valid = o_valid_q;
  assign o_spike = o_spike_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_pool_if_neuron.sv
`timescale 1ns/1ps
// Bench for pool_if_neuron: three parameterisations share one stimulus bus; a
// scoreboard queue holds expected spike beats for whichever instance is selected.
module tb_pool_if_neuron;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       vs = 1'b0, hs = 1'b0, rg = 1'b0, vl = 1'b0, clr = 1'b0;
  logic [2:0] td = '0;

  logic [2:0] o_vs, o_hs, o_rg, o_vl, o_sp, o_ov;

  always #5 clk = ~clk;

  pool_if_neuron #(.IW(3), .VW(8), .THRESH(4), .MAX_PIX(196), .AW(8)) u0 (
    .i_sclk(clk), .i_rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_range(rg),
    .i_valid(vl), .i_tdata(td), .i_clr(clr),
    .o_vsync(o_vs[0]), .o_hsync(o_hs[0]), .o_range(o_rg[0]),
    .o_valid(o_vl[0]), .o_spike(o_sp[0]), .o_ovf(o_ov[0]));

  pool_if_neuron #(.IW(3), .VW(3), .THRESH(7), .MAX_PIX(4), .AW(2)) u1 (
    .i_sclk(clk), .i_rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_range(rg),
    .i_valid(vl), .i_tdata(td), .i_clr(clr),
    .o_vsync(o_vs[1]), .o_hsync(o_hs[1]), .o_range(o_rg[1]),
    .o_valid(o_vl[1]), .o_spike(o_sp[1]), .o_ovf(o_ov[1]));

  pool_if_neuron #(.IW(3), .VW(8), .THRESH(4), .MAX_PIX(1), .AW(1)) u2 (
    .i_sclk(clk), .i_rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_range(rg),
    .i_valid(vl), .i_tdata(td), .i_clr(clr),
    .o_vsync(o_vs[2]), .o_hsync(o_hs[2]), .o_range(o_rg[2]),
    .o_valid(o_vl[2]), .o_spike(o_sp[2]), .o_ovf(o_ov[2]));

  typedef struct {
    logic spk;
    int   due;
  } exp_t;

  exp_t       q[$];
  int         cyc    = 0;
  int         n_vec  = 0;
  int         n_bad  = 0;
  int         sel    = 0;
  bit         mon_en = 1'b0;
  logic [2:0] f_d1   = '0;
  logic [2:0] f_d2   = '0;

  // Cycle count and expected framing, two input samples back.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      f_d1 <= '0;
      f_d2 <= '0;
    end else begin
      f_d1 <= {vs, hs, rg};
      f_d2 <= f_d1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d, dut %0d)", name, act, exp, cyc, sel);
    end
  endtask

  // Monitor: compares every output beat of the selected instance against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("framing", 32'({o_vs[sel], o_hs[sel], o_rg[sel]}), 32'(f_d2));
      if (o_vl[sel]) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'(o_vl[sel]), 32'd0);
        end else begin
          e = q.pop_front();
          chk("spike", 32'(o_sp[sel]), 32'(e.spk));
          chk("latency", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("spike_idle", 32'(o_sp[sel]), 32'd0);
        if (q.size() > 0 && q[0].due < cyc) begin
          e = q.pop_front();
          chk("missing_valid", 32'(o_vl[sel]), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic spk);
    exp_t e;
    e.spk = spk;
    e.due = cyc + 2;
    q.push_back(e);
  endtask

  // One frame: vsync, then rows of up to 14 back-to-back beats. Beat sidx gets
  // its own data/expected spike; beats at index >= mx are expected to be dropped.
  task automatic send_frame(input logic clr_v, input int n, input int mx,
                            input logic [2:0] d_all, input logic s_all,
                            input int sidx, input logic [2:0] sdat, input logic ssp,
                            input bit ovf_chk);
    int i;
    i   = 0;
    vs  = 1'b1;
    clr = clr_v;
    tick();
    vs  = 1'b0;
    clr = 1'b0;
    tick();
    while (i < n) begin
      hs = 1'b1;
      tick();
      hs = 1'b0;
      rg = 1'b1;
      for (int c = 0; c < 14 && i < n; c++) begin
        vl = 1'b1;
        td = (i == sidx) ? sdat : d_all;
        if (i < mx) push_exp((i == sidx) ? ssp : s_all);
        tick();
        if (ovf_chk) chk("ovf_rise", 32'(o_ov[sel]), 32'(i >= mx));
        i++;
      end
      vl = 1'b0;
      rg = 1'b0;
      tick();
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic reset_to(input int new_sel);
    rstn = 1'b0;
    {vs, hs, rg, vl, clr} = '0;
    td   = '0;
    tick();
    tick();
    sel  = new_sel;
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    for (int k = 0; k < 3; k++)
      chk("reset_outputs", 32'({o_vs[k], o_hs[k], o_rg[k], o_vl[k], o_sp[k], o_ov[k]}), 32'd0);
    mon_en = 1'b1;

    // 8-bit membranes, threshold 4, 196 pixels.
    reset_to(0);
    send_frame(1'b1, 196, 196, 3'd2, 1'b0, -1, 3'd0, 1'b0, 1'b0);
    send_frame(1'b0, 196, 196, 3'd2, 1'b1, -1, 3'd0, 1'b0, 1'b0);
    send_frame(1'b0, 196, 196, 3'd2, 1'b0, -1, 3'd0, 1'b0, 1'b0);
    // Pixel 5 driven with 7: sums 7, 10, 13, 16 -> spikes every frame.
    send_frame(1'b1, 196, 196, 3'd0, 1'b0, 5, 3'd7, 1'b1, 1'b0);
    send_frame(1'b0, 196, 196, 3'd0, 1'b0, 5, 3'd7, 1'b1, 1'b0);
    send_frame(1'b0, 196, 196, 3'd0, 1'b0, 5, 3'd7, 1'b1, 1'b0);
    send_frame(1'b0, 196, 196, 3'd0, 1'b0, 5, 3'd7, 1'b1, 1'b0);
    // Overlong frame: 200 beats, only 196 emitted, overflow sticky past vsync.
    send_frame(1'b1, 200, 196, 3'd0, 1'b0, -1, 3'd0, 1'b0, 1'b1);
    send_frame(1'b0, 0, 196, 3'd0, 1'b0, -1, 3'd0, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(o_ov[0]), 32'd1);
    drain();

    // 3-bit membranes, threshold 7: pixel 0 fed 7,6,6,1,7 -> v 0,6,5,6,6.
    reset_to(1);
    send_frame(1'b1, 4, 4, 3'd0, 1'b0, 0, 3'd7, 1'b1, 1'b0);
    send_frame(1'b0, 4, 4, 3'd0, 1'b0, 0, 3'd6, 1'b0, 1'b0);
    send_frame(1'b0, 4, 4, 3'd0, 1'b0, 0, 3'd6, 1'b1, 1'b0);
    send_frame(1'b0, 4, 4, 3'd0, 1'b0, 0, 3'd1, 1'b0, 1'b0);
    send_frame(1'b0, 4, 4, 3'd0, 1'b0, 0, 3'd7, 1'b1, 1'b0);
    chk("ovf_clear", 32'(o_ov[1]), 32'd0);
    drain();

    // Single pixel: beat, vsync, beat in consecutive cycles (3 then 3+3=6 fires).
    reset_to(2);
    vs = 1'b1; clr = 1'b1; tick();
    vs = 1'b0; clr = 1'b0; tick();
    vl = 1'b1; td = 3'd3; push_exp(1'b0); tick();
    vl = 1'b0; vs = 1'b1; tick();
    vs = 1'b0; vl = 1'b1; td = 3'd3; push_exp(1'b1); tick();
    vl = 1'b0;
    repeat (4) tick();
    // Reset while a beat is in flight: beat vanishes, outputs zero next cycle.
    vs = 1'b1; tick();
    vs = 1'b0; vl = 1'b1; td = 3'd3; tick();
    vl = 1'b0; rstn = 1'b0; tick();
    chk("midframe_reset", 32'({o_vs[2], o_hs[2], o_rg[2], o_vl[2], o_sp[2], o_ov[2]}), 32'd0);
    rstn = 1'b1; tick();
    // Membrane held 2; after reset the frame must start from 0 even with clr=0.
    send_frame(1'b0, 1, 1, 3'd3, 1'b0, -1, 3'd0, 1'b0, 1'b0);
    send_frame(1'b0, 1, 1, 3'd3, 1'b1, -1, 3'd0, 1'b0, 1'b0);
    drain();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
